sdram_frame_writer: RTL

Write-side client of the `ian_sdram` controller; the counterpart of the `sdram_image` reader. It accepts a stream of 16-bit pixel words through a valid/ready handshake and buffers them in a 4-entry FIFO. Once a frame is started, it claims the controller, writes one full frame of words to consecutive SDRAM addresses beginning at `BASE_ADDR`, then releases the controller. It sits between a pixel source (camera, UART loader, pattern generator) and the `ian_sdram` client port in `top`.

---
 rtl/sdram_frame_writer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer: buffers a 16-bit pixel stream in a 4-deep FIFO and
// writes one frame of words to consecutive SDRAM addresses through the
// ian_sdram client port, holding controller focus for the whole frame.
module sdram_frame_writer #(
    parameter logic [24:0] BASE_ADDR   = 25'h0000000,
    parameter int unsigned FRAME_WORDS = 307200
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        busy,
    output logic        done,
    output logic [24:0] word_count,
    output logic [24:0] sdram_Addr,
    output logic [15:0] sdram_Din,
    output logic        sdram_WE,
    output logic        sdram_Direction,
    output logic        sdram_Focus,
    output logic        sdram_Act,
    input  logic        sdram_R
);

    localparam int unsigned AW    = 25;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 3;

    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] wr_ptr_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_pop;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;

    logic [AW-1:0] addr_next;
    logic [AW-1:0] wcount_next;
    logic [DW-1:0] din_next;
    logic          act_next;
    logic          focus_next;
    logic          done_next;

    // Decoded status: accept words only while a frame is actively being written
    assign pix_ready       = (count < CW'(DEPTH)) && (state != IDLE) && (state != DONE);
    assign busy            = (state != IDLE);
    assign sdram_Direction = 1'b1;
    assign push            = pix_valid && pix_ready;

    // Next-state logic: frame sequencing, address and word counting
    always_comb begin
        state_next  = state;
        addr_next   = sdram_Addr;
        wcount_next = word_count;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = ISSUE;
                    addr_next   = BASE_ADDR;
                    wcount_next = '0;
                end
            end
            ISSUE: begin
                if (count != '0) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (sdram_R) begin
                    pop         = 1'b1;
                    addr_next   = sdram_Addr + AW'(1);
                    wcount_next = word_count + AW'(1);
                    state_next  = (word_count == LAST_IDX) ? DONE : ISSUE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; DONE discards any words left over from the frame
    always_comb begin
        count_after_pop = count - CW'(pop);
        count_next      = count_after_pop + CW'(push);
        rd_ptr_next     = rd_ptr + PW'(pop);
        wr_ptr_next     = wr_ptr + PW'(push);
        if (state == DONE) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end
    end

    // Registered-output precompute: strobe Act in the ISSUE cycle that has data
    always_comb begin
        act_next   = (state_next == ISSUE) && (count_next != '0);
        focus_next = (state_next != IDLE);
        done_next  = (state_next == DONE);
        din_next   = sdram_Din;
        if (act_next) begin
            // An empty FIFO after the pop means the head is the word being pushed now
            din_next = (count_after_pop == '0) ? pix_data : mem[rd_ptr_next];
        end
    end

    // FIFO storage needs no reset; occupancy and pointers define validity
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= pix_data;
        end
    end

    // State, FIFO pointers and all registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            sdram_Act   <= 1'b0;
            sdram_Focus <= 1'b0;
            sdram_WE    <= 1'b0;
            done        <= 1'b0;
            sdram_Addr  <= '0;
            sdram_Din   <= '0;
            word_count  <= '0;
        end else begin
            state       <= state_next;
            rd_ptr      <= rd_ptr_next;
            wr_ptr      <= wr_ptr_next;
            count       <= count_next;
            sdram_Act   <= act_next;
            sdram_Focus <= focus_next;
            sdram_WE    <= focus_next;
            done        <= done_next;
            sdram_Addr  <= addr_next;
            sdram_Din   <= din_next;
            word_count  <= wcount_next;
        end
    end

endmodule
